cpu_m: RTL and testbench
========================

# cpu_m

Minimal 8-bit CPU with a 1-bit serial instruction input and four 8-bit general registers (A–D) exposed as outputs, plus zero and sign flags. Instructions arrive bit-serially on `ins` in framed bytes (start bit + 8 data bits, MSB first) and are executed one at a time. It is the top-level compute block of the design. All state is visible on the output ports for observation.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ins`  in  1  serial instruction stream; idle level 0.
- `ra`  out  8  register A.
- `rb`  out  8  register B.
- `rc`  out  8  register C.
- `rd`  out  8  register D.
- `zf`  out  1  zero flag.
- `sf`  out  1  sign flag (bit 7 of the last flag-setting result).

## Operation
- Frame: in IDLE, a sampled `ins`=1 is a start bit; the next 8 samples are data bits, MSB first. `ins`=0 in IDLE is ignored, so holding `ins`=0 does nothing.
- Instruction byte: [7:4] opcode, [3:2] dst (00=A, 01=B, 10=C, 11=D), [1:0] src.
- Opcodes (result r, written to dst unless noted):
  - 0 NOP.
  - 1 MOV: r=src.
  - 2 ADD: r=dst+src.
  - 3 SUB: r=dst−src.
  - 4 AND, 5 OR, 6 XOR: dst op src.
  - 7 NOT: r=~src.
  - 8 SHL: r=src<<1.
  - 9 SHR: r=src>>1, logical.
  - A LDI: r=imm.
  - B CMP: r=dst−src, flags only, no write.
  - C INC: r=dst+1.
  - D DEC: r=dst−1.
  - E CLR: r=0.
  - F ADDI: r=dst+imm.
- Immediate: opcodes A and F require a second frame (start bit + 8 bits) carrying imm. Between the two frames, the line may idle at 0 for any number of cycles.
- Arithmetic is 8-bit modulo 256; no carry or overflow flag.
- Flags: zf=(r==0), sf=r[7].
  - Updated by opcodes 2–9, B–F.
  - Unchanged by NOP, MOV, LDI.
- When dst==src, the operation uses the pre-instruction value (e.g. ADD A,A doubles A).

## Timing
- States: IDLE → SHIFT (8 cycles) → EXEC (1 cycle) → IDLE. For opcodes A/F: SHIFT → WAIT_IMM → SHIFT_IMM (8 cycles) → EXEC → IDLE.
- WAIT_IMM behaves like IDLE: it waits for a start bit.
- Start bit sampled at edge n; data bits at edges n+1..n+8. The register/flag update is visible after edge n+9 (EXEC).
- The earliest next start bit is sampled at edge n+10. A 1 on `ins` during EXEC is ignored.
- Reset (`rst_n`=0, asynchronous): ra=rb=rc=rd=0x00, zf=0, sf=0, state=IDLE, shift register and bit counter cleared.
  - Reset mid-frame or between opcode and immediate aborts the instruction with no register write.
- After `rst_n` rises, the first edge with `ins`=1 is a start bit.

## Test plan
- Reset, then hold `ins`=0 for 100 ns → all registers 0x00, zf=0, sf=0, no change.
- Send LDI A (0xA0) then imm 0x05; send LDI B (0xA4) then imm 0x05 → ra=0x05, rb=0x05, flags still 0. ra changes exactly 1 cycle after the last imm bit.
- Send SUB A,B (0x31) → ra=0x00, zf=1, sf=0. Then send DEC A (0xD0) → ra=0xFF, zf=0, sf=1.
- Load A=0x80 (0xA0, imm 0x80), then send ADD A,A (0x20) → ra=0x00, zf=1, sf=0. Then send CMP on B=0x05 vs A via 0xB4 → rb unchanged, zf=0, sf=0.
- Send 0xA8 (LDI C), then assert `rst_n`=0 mid-way through the immediate frame → all outputs 0 immediately. A subsequent full LDI C, 0x3C → rc=0x3C.
- Send NOT D,A with A=0x0F (0x7C) → rd=0xF0, sf=1. Then send SHR D,D (0x9F) → rd=0x78, sf=0, zf=0.

Source files
------------

// File: rtl/cpu_m.sv
// cpu_m: minimal 8-bit CPU fed by a bit-serial instruction stream.
//
// Frames are a start bit (1) followed by 8 data bits, MSB first. An
// instruction byte is {opcode[3:0], dst[1:0], src[1:0]}. LDI (A) and
// ADDI (F) take a second frame carrying the immediate.
//
// Ports:
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   ins    in  1  serial instruction stream, idles at 0
//   ra..rd out 8  general registers A..D
//   zf     out 1  zero flag of the last flag-setting result
//   sf     out 1  sign flag (bit 7) of the last flag-setting result
module cpu_m (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ins,
  output logic [7:0] ra,
  output logic [7:0] rb,
  output logic [7:0] rc,
  output logic [7:0] rd,
  output logic       zf,
  output logic       sf
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_IMM,
    SHIFT_IMM,
    EXEC
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          cnt;
  logic [DATA_W-1:0]   sh;
  logic [DATA_W-1:0]   ir;
  logic [3:0][DATA_W-1:0] regs;

  logic [DATA_W-1:0]   byte_in;
  logic                byte_done;
  logic                needs_imm;
  logic [3:0]          op;
  logic [DATA_W-1:0]   dst_val;
  logic [DATA_W-1:0]   src_val;
  logic [DATA_W-1:0]   result;
  logic                wr_en;
  logic                flag_en;

  function automatic logic [DATA_W-1:0] alu(
    input logic [3:0]        opc,
    input logic [DATA_W-1:0] d,
    input logic [DATA_W-1:0] s,
    input logic [DATA_W-1:0] imm
  );
    logic [DATA_W-1:0] r;
    case (opc)
      4'h1:    r = s;
      4'h2:    r = d + s;
      4'h3:    r = d - s;
      4'h4:    r = d & s;
      4'h5:    r = d | s;
      4'h6:    r = d ^ s;
      4'h7:    r = ~s;
      4'h8:    r = {s[DATA_W-2:0], 1'b0};
      4'h9:    r = {1'b0, s[DATA_W-1:1]};
      4'hA:    r = imm;
      4'hB:    r = d - s;
      4'hC:    r = d + 8'd1;
      4'hD:    r = d - 8'd1;
      4'hF:    r = d + imm;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Byte as it will look once the current data bit is shifted in.
  assign byte_in   = {sh[DATA_W-2:0], ins};
  assign byte_done = (cnt == 3'd7);
  assign needs_imm = (byte_in[7:4] == 4'hA) || (byte_in[7:4] == 4'hF);

  assign op      = ir[7:4];
  // Operands are read from the pre-instruction register file, so dst==src
  // naturally uses the old value.
  assign dst_val = regs[ir[3:2]];
  assign src_val = regs[ir[1:0]];

  always_comb begin
    result  = alu(op, dst_val, src_val, sh);
    wr_en   = (op != 4'h0) && (op != 4'hB);
    flag_en = (op != 4'h0) && (op != 4'h1) && (op != 4'hA);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (ins) state_nxt = SHIFT;
      SHIFT:     if (byte_done) state_nxt = needs_imm ? WAIT_IMM : EXEC;
      WAIT_IMM:  if (ins) state_nxt = SHIFT_IMM;
      SHIFT_IMM: if (byte_done) state_nxt = EXEC;
      EXEC:      state_nxt = IDLE;   // a 1 on ins here is not a start bit
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sh   <= '0;
      ir   <= '0;
      regs <= '0;
      zf   <= 1'b0;
      sf   <= 1'b0;
    end else begin
      case (state)
        SHIFT, SHIFT_IMM: begin
          cnt <= cnt + 3'd1;
          sh  <= byte_in;
          // Latch the opcode byte so the immediate frame can reuse sh.
          if (state == SHIFT && byte_done) ir <= byte_in;
        end
        EXEC: begin
          cnt <= '0;
          if (wr_en)   regs[ir[3:2]] <= result;
          if (flag_en) begin
            zf <= (result == '0);
            sf <= result[DATA_W-1];
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign ra = regs[0];
  assign rb = regs[1];
  assign rc = regs[2];
  assign rd = regs[3];

endmodule

// File: tb/tb_cpu_m.sv
module tb_cpu_m;

  logic       clk;
  logic       rst_n;
  logic       ins;
  logic [7:0] ra, rb, rc, rd;
  logic       zf, sf;

  int checks   = 0;
  int failures = 0;

  cpu_m dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ins   (ins),
    .ra    (ra),
    .rb    (rb),
    .rc    (rc),
    .rd    (rd),
    .zf    (zf),
    .sf    (sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Start bit plus 8 data bits; returns at the falling edge just before
  // the EXEC edge with ins back at 0.
  task automatic send_frame(input logic [7:0] b);
    @(negedge clk) ins = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) ins = b[i];
    end
    @(negedge clk) ins = 1'b0;
  endtask

  task automatic exec_instr(input logic [7:0] b);
    send_frame(b);
    @(negedge clk);
  endtask

  task automatic exec_imm(input logic [7:0] b, input logic [7:0] imm);
    send_frame(b);
    repeat (3) @(negedge clk);
    send_frame(imm);
    @(negedge clk);
  endtask

  task automatic check_flags(input string tag, input logic ez, input logic es);
    check({tag, "_zf"}, {7'd0, zf}, {7'd0, ez});
    check({tag, "_sf"}, {7'd0, sf}, {7'd0, es});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ins   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle line does nothing.
    repeat (10) @(negedge clk);
    check("rst_ra", ra, 8'h00);
    check("rst_rb", rb, 8'h00);
    check("rst_rc", rc, 8'h00);
    check("rst_rd", rd, 8'h00);
    check_flags("rst", 1'b0, 1'b0);

    // LDI A,0x05 with exact-latency check on the immediate frame.
    send_frame(8'hA0);
    repeat (2) @(negedge clk);
    @(negedge clk) ins = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) ins = logic'(8'h05 >> i);
    end
    @(negedge clk) ins = 1'b0;
    check("ldi_a_before_exec", ra, 8'h00);
    @(negedge clk);
    check("ldi_a", ra, 8'h05);
    exec_imm(8'hA4, 8'h05);
    check("ldi_b", rb, 8'h05);
    check_flags("ldi", 1'b0, 1'b0);

    // SUB A,B then DEC A.
    exec_instr(8'h31);
    check("sub_ra", ra, 8'h00);
    check_flags("sub", 1'b1, 1'b0);
    exec_instr(8'hD0);
    check("dec_ra", ra, 8'hFF);
    check_flags("dec", 1'b0, 1'b1);

    // A=0x80, ADD A,A wraps to 0; CMP B,A leaves B.
    exec_imm(8'hA0, 8'h80);
    check("ldi_a80", ra, 8'h80);
    exec_instr(8'h20);
    check("add_aa", ra, 8'h00);
    check_flags("add", 1'b1, 1'b0);
    exec_instr(8'hB4);
    check("cmp_rb", rb, 8'h05);
    check_flags("cmp", 1'b0, 1'b0);

    // INC A with ins held high during EXEC: must not start a new frame.
    send_frame(8'hC0);
    ins = 1'b1;
    @(negedge clk) ins = 1'b0;
    check("inc_ra", ra, 8'h01);
    repeat (12) @(negedge clk);
    check("exec_ignore_ra", ra, 8'h01);
    check("exec_ignore_rb", rb, 8'h05);

    // ADDI A,0xFF wraps to zero.
    exec_imm(8'hF0, 8'hFF);
    check("addi_ra", ra, 8'h00);
    check_flags("addi", 1'b1, 1'b0);

    // LDI C aborted by reset in the middle of the immediate frame.
    send_frame(8'hA8);
    repeat (2) @(negedge clk);
    @(negedge clk) ins = 1'b1;
    @(negedge clk) ins = 1'b0;
    @(negedge clk) ins = 1'b1;
    @(negedge clk) ins = 1'b1;
    #2 rst_n = 1'b0;
    ins = 1'b0;
    #1;
    check("abort_ra", ra, 8'h00);
    check("abort_rb", rb, 8'h00);
    check("abort_rc", rc, 8'h00);
    check("abort_rd", rd, 8'h00);
    check_flags("abort", 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_rc_after", rc, 8'h00);
    exec_imm(8'hA8, 8'h3C);
    check("ldi_c", rc, 8'h3C);

    // NOT D,A with A=0x0F, then SHR D,D, then SHL D,D.
    exec_imm(8'hA0, 8'h0F);
    check("ldi_a0f", ra, 8'h0F);
    exec_instr(8'h7C);
    check("not_rd", rd, 8'hF0);
    check_flags("not", 1'b0, 1'b1);
    exec_instr(8'h9F);
    check("shr_rd", rd, 8'h78);
    check_flags("shr", 1'b0, 1'b0);
    exec_instr(8'h8F);
    check("shl_rd", rd, 8'hF0);
    check_flags("shl", 1'b0, 1'b1);

    // CLR B sets zf; MOV A,D must leave flags alone.
    exec_instr(8'hE4);
    check("clr_rb", rb, 8'h00);
    check_flags("clr", 1'b1, 1'b0);
    exec_instr(8'h13);
    check("mov_ra", ra, 8'hF0);
    check_flags("mov", 1'b1, 1'b0);

    // XOR C,A: 0x3C ^ 0xF0 = 0xCC.
    exec_instr(8'h68);
    check("xor_rc", rc, 8'hCC);
    check_flags("xor", 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
